// File: rtl/amp_comp_flex.sv
// amp_comp_flex: sliding-window amplitude compressor with valid qualification.
// Keeps the last WINDOW accepted signed samples and tracks the window peak magnitude.
// When that peak exceeds the threshold, the oldest sample is attenuated in
// proportion to the excess. The result is produced through a 2-stage registered pipeline.
//
// Parameters: DATA_W (sample width), WINDOW (depth), THR_W (threshold width),
//             RATIO_SH (extra right shift of the reduction term).
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   in_valid   sample strobe, in_data accepted when 1
//   in_data    signed input sample
//   in_thresh  threshold, T = in_thresh << (DATA_W-1-THR_W)
//   bypass     pass the oldest sample unmodified (same latency)
//   out_valid  output strobe
//   out_data   signed compressed sample (held between strobes)
//   comp_count 16-bit saturating count of compressed outputs
//              (only when AMP_COMP_STATS_EN is defined)
module amp_comp_flex #(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned WINDOW   = 4,
   parameter int unsigned THR_W    = 4,
   parameter int unsigned RATIO_SH = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic [THR_W-1:0]  in_thresh,
   input  logic              bypass,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data
`ifdef AMP_COMP_STATS_EN
   ,
   output logic [15:0]       comp_count
`endif
);

   localparam int unsigned       FILL_W  = $clog2(WINDOW + 1);
   localparam logic [FILL_W-1:0] FULL    = FILL_W'(WINDOW);
   localparam logic [DATA_W-1:0] MAG_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] NEG_MIN = {1'b1, {(DATA_W-1){1'b0}}};

   // Magnitude with the most negative value saturated to the largest positive value.
   function automatic logic [DATA_W-1:0] mag_f(input logic [DATA_W-1:0] x);
      if (x == NEG_MIN)       return MAG_MAX;
      else if (x[DATA_W-1])   return -x;
      else                    return x;
   endfunction

   logic [DATA_W-1:0] win_q [WINDOW];
   logic [FILL_W-1:0] fill_q, fill_d;
   logic              acc_q, acc_d;     // previous edge accepted a sample into a full window

   logic [DATA_W-1:0] peak_c, thr_c;
   logic [DATA_W-1:0] peak_q, s1_q, t1_q;
   logic              byp1_q, v1_q;

   logic [DATA_W-1:0] mag_s1_c, exc_c, red_c, cmp_c;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_valid_q;

   always_comb begin
      fill_d = fill_q;
      if (in_valid && (fill_q != FULL)) fill_d = fill_q + FILL_W'(1);
      acc_d = in_valid && (fill_d == FULL);

      thr_c = {1'b0, in_thresh, {(DATA_W-1-THR_W){1'b0}}};

      peak_c = '0;
      for (int unsigned i = 0; i < WINDOW; i++) begin
         if (mag_f(win_q[i]) > peak_c) peak_c = mag_f(win_q[i]);
      end

      mag_s1_c = mag_f(s1_q);
      exc_c    = (peak_q > t1_q) ? (peak_q - t1_q) : '0;
      // Both truncating shifts folded into one: the full 2*DATA_W product is kept until then.
      red_c    = DATA_W'(({{DATA_W{1'b0}}, mag_s1_c} * {{DATA_W{1'b0}}, exc_c})
                         >> (DATA_W - 1 + RATIO_SH));
      cmp_c    = mag_s1_c - red_c;

      out_data_d = out_data_q;
      if (v1_q) out_data_d = byp1_q ? s1_q : (s1_q[DATA_W-1] ? -cmp_c : cmp_c);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < WINDOW; i++) win_q[i] <= '0;
         fill_q <= '0;
         acc_q  <= 1'b0;
      end else begin
         if (in_valid) begin
            win_q[0] <= in_data;
            for (int unsigned i = 1; i < WINDOW; i++) win_q[i] <= win_q[i-1];
         end
         fill_q <= fill_d;
         acc_q  <= acc_d;
      end
   end

   // Stage 1 reads the window as it stood after the accepting edge, before any further shift.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         peak_q <= '0;
         s1_q   <= '0;
         t1_q   <= '0;
         byp1_q <= 1'b0;
         v1_q   <= 1'b0;
      end else begin
         v1_q <= acc_q;
         if (acc_q) begin
            peak_q <= peak_c;
            s1_q   <= win_q[WINDOW-1];
            t1_q   <= thr_c;
            byp1_q <= bypass;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         out_valid_q <= v1_q;
         out_data_q  <= out_data_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

`ifdef AMP_COMP_STATS_EN
   logic [15:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (v1_q && !byp1_q && (red_c != '0) && (cnt_q != 16'hFFFF)) begin
         cnt_q <= cnt_q + 16'd1;
      end
   end

   assign comp_count = cnt_q;
`endif

endmodule

// File: tb/tb_amp_comp_flex.sv
// Testbench for amp_comp_flex: directed literal cases plus randomized stream
// checked every cycle against a behavioural model.
module tb_amp_comp_flex;

   localparam int DW  = 16;
   localparam int WIN = 4;
   localparam int TW  = 4;
   localparam int RS  = 0;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic [TW-1:0] in_thresh = '0;
   logic          bypass = 1'b0;
   logic          out_valid;
   logic [DW-1:0] out_data;
`ifdef AMP_COMP_STATS_EN
   logic [15:0]   comp_count;
`endif

   int errors = 0;
   int checks = 0;

   amp_comp_flex #(.DATA_W(DW), .WINDOW(WIN), .THR_W(TW), .RATIO_SH(RS)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_thresh (in_thresh),
      .bypass    (bypass),
      .out_valid (out_valid),
      .out_data  (out_data)
`ifdef AMP_COMP_STATS_EN
      ,
      .comp_count(comp_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic int magn(input int x);
      if (x == -(1 << (DW-1))) return (1 << (DW-1)) - 1;
      return (x < 0) ? -x : x;
   endfunction

   // Result for oldest sample s given window peak, raw threshold and bypass.
   function automatic logic [DW-1:0] model_out(input int s, input int peak, input int thr,
                                               input bit byp, output bit compressed);
      int t, e, ms, red, m, res;
      longint prod;
      logic [31:0] r32;
      t     = thr << (DW-1-TW);
      e     = (peak > t) ? peak - t : 0;
      ms    = magn(s);
      prod  = longint'(ms) * longint'(e);
      red   = int'(prod / (64'sd1 << (DW-1)));
      red   = red / (1 << RS);
      m     = ms - red;
      res   = byp ? s : ((s < 0) ? -m : m);
      compressed = !byp && (red > 0);
      r32   = res;
      return r32[DW-1:0];
   endfunction

   int            m_win [WIN];
   int            m_fill;
   bit            m_acc;       // accepted sample made the window full on this edge
   bit            m_mid_v;     // one edge into the 2-edge latency
   logic [DW-1:0] m_mid_d;
   bit            m_mid_c;
   bit            m_ov;
   logic [DW-1:0] m_od;
   int            m_cnt;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < WIN; i++) m_win[i] = 0;
         m_fill = 0; m_acc = 0; m_mid_v = 0; m_mid_d = '0; m_mid_c = 0;
         m_ov = 0; m_od = '0; m_cnt = 0;
      end else begin
         m_ov = m_mid_v;
         if (m_mid_v) begin
            m_od = m_mid_d;
            if (m_mid_c && m_cnt < 16'hFFFF) m_cnt++;
         end
         m_mid_v = m_acc;
         if (m_acc) begin
            int pk;
            pk = 0;
            for (int i = 0; i < WIN; i++) if (magn(m_win[i]) > pk) pk = magn(m_win[i]);
            m_mid_d = model_out(m_win[WIN-1], pk, int'(in_thresh), bypass, m_mid_c);
         end
         if (in_valid) begin
            for (int i = WIN-1; i > 0; i--) m_win[i] = m_win[i-1];
            m_win[0] = int'($signed(in_data));
            if (m_fill < WIN) m_fill++;
         end
         m_acc = in_valid && (m_fill == WIN);
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (!rst) begin
         chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
         chk("out_data", {16'd0, out_data}, {16'd0, m_od});
`ifdef AMP_COMP_STATS_EN
         chk("comp_count", {16'd0, comp_count}, m_cnt);
`endif
      end
   end

   // ---------------- directed helpers ----------------
   // Called just after a rising edge; asserts reset mid-cycle and checks it acts at once.
   task automatic do_reset();
      #3 rst = 1'b1;
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", {16'd0, out_data}, 32'd0);
      @(posedge clk); @(posedge clk);
      #1 rst = 1'b0;
      in_valid = 1'b0;
   endtask

   task automatic run_case(input string name, input logic [DW-1:0] s0, input logic [DW-1:0] s1,
                           input logic [DW-1:0] s2, input logic [DW-1:0] s3,
                           input logic [TW-1:0] thr, input bit byp, input int gap,
                           input logic [DW-1:0] exp);
      logic [DW-1:0] q [4];
      int n;
      q[0] = s0; q[1] = s1; q[2] = s2; q[3] = s3;
      in_valid = 1'b1;
      in_data  = 16'h5A5A;
      do_reset();
      in_thresh = thr;
      bypass    = byp;
      for (int k = 0; k < 4; k++) begin
         if (k != 0) repeat (gap) @(posedge clk);
         #1;
         in_valid = 1'b1;
         in_data  = q[k];
         @(posedge clk);
         #1 in_valid = 1'b0;
      end
      n = 0;
      for (int w = 1; w <= 8; w++) begin
         @(negedge clk);
         if (out_valid) begin n = w; break; end
      end
      if (n == 0) n = 99;
      chk({name, "_latency"}, n, 32'd3);
      chk({name, "_data"}, {16'd0, out_data}, {16'd0, exp});
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic feed(input int count, input logic [DW-1:0] d);
      for (int k = 0; k < count; k++) begin
         in_valid = 1'b1;
         in_data  = d;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      checks++;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      run_case("below_thr", 16'h1000, 16'h1000, 16'h1000, 16'h1000, 4'd4, 1'b0, 0, 16'h1000);
      run_case("pos_comp",  16'h4000, 16'h4000, 16'h4000, 16'h4000, 4'd4, 1'b0, 0, 16'h3000);
      run_case("neg_comp",  16'hC000, 16'hC000, 16'hC000, 16'hC000, 4'd4, 1'b0, 0, 16'hD000);
      run_case("min_sat",   16'h8000, 16'h8000, 16'h8000, 16'h8000, 4'd4, 1'b0, 0, 16'hDFFF);
      run_case("min_byp",   16'h8000, 16'h8000, 16'h8000, 16'h8000, 4'd4, 1'b1, 0, 16'h8000);
      run_case("peak_new",  16'h0100, 16'h0100, 16'h0100, 16'h6000, 4'd4, 1'b0, 0, 16'h0080);
      run_case("peak_gap",  16'h0100, 16'h0100, 16'h0100, 16'h6000, 4'd4, 1'b0, 3, 16'h0080);
      run_case("peak_eq_t", 16'h2000, 16'h2000, 16'h2000, 16'h2000, 4'd4, 1'b0, 0, 16'h2000);
      run_case("t0_zero",   16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'd0, 1'b0, 0, 16'h0000);

      // Randomized stream with gaps, threshold/bypass changes and occasional resets.
      for (int c = 0; c < 3000; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 5))
            0:       in_data = 16'h8000;
            1:       in_data = 16'h7FFF;
            2:       in_data = 16'($urandom_range(0, 255));
            default: in_data = 16'($urandom);
         endcase
         in_thresh = 4'($urandom);
         bypass    = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 399) == 0) do_reset();
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;

`ifdef AMP_COMP_STATS_EN
      in_valid = 1'b1;
      do_reset();
      in_thresh = 4'd4;
      bypass    = 1'b0;
      feed(8, 16'h4000);
      bypass = 1'b1;
      feed(3, 16'h4000);
      chk("stats_five", {16'd0, comp_count}, 32'd5);
      bypass = 1'b0;
      feed(32'h10005, 16'h4000);
      chk("stats_sat", {16'd0, comp_count}, 32'h0000FFFF);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
